// File: rtl/i2c_rtc_slave.sv
// I2C slave bus engine for the PCF8583 clock/CMOS emulation: filters SCL/SDA, decodes START/STOP,
// matches DEV_ADDR, owns the register pointer and drives the register file write/read interface.
module i2c_rtc_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEVADDR, S_ACK_DEV, S_PTR, S_ACK_PTR,
        S_WDATA, S_ACK_W, S_RDATA, S_MACK, S_WAIT_STOP
    } state_t;

    logic [1:0]    scl_s_q, sda_s_q;
    logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;

    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          rw_q, mack_q;
    logic          sda_oe_q, reg_we_q;
    logic [7:0]    reg_addr_q, reg_wdata_q;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_rise  = scl_f_q & ~scl_p_q;
    assign scl_fall  = ~scl_f_q & scl_p_q;
    assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
    assign byte_in   = {shift_q[6:0], sda_f_q};

    assign sda_oe    = sda_oe_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

    // A level change is accepted only after FILT_LEN consecutive differing synchronised samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s_q   <= 2'b11;
            sda_s_q   <= 2'b11;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            scl_s_q <= {scl_s_q[0], scl_i};
            sda_s_q <= {sda_s_q[0], sda_i};
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            if (scl_s_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CNT_MAX) begin
                scl_f_q   <= scl_s_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CW'(1);
            end
            if (sda_s_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CNT_MAX) begin
                sda_f_q   <= sda_s_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            mack_q      <= 1'b1;
            sda_oe_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
        end else begin
            reg_we_q <= 1'b0;
            if (reg_we_q) begin
                reg_addr_q <= reg_addr_q + 8'd1;
            end
            if (start_det) begin
                state_q   <= S_DEVADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_DEVADDR, S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                if (state_q == S_DEVADDR) begin
                                    rw_q    <= byte_in[0];
                                    state_q <= (byte_in[7:1] == DEV_ADDR) ? S_ACK_DEV : S_WAIT_STOP;
                                end else if (state_q == S_PTR) begin
                                    reg_addr_q <= byte_in;
                                    state_q    <= S_ACK_PTR;
                                end else begin
                                    reg_wdata_q <= byte_in;
                                    reg_we_q    <= 1'b1;
                                    state_q     <= S_ACK_W;
                                end
                            end
                        end
                    end
                    // First SCL fall in an ACK state pulls SDA low, the second one ends the ACK.
                    S_ACK_DEV, S_ACK_PTR, S_ACK_W: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                if (state_q == S_ACK_DEV && rw_q) begin
                                    shift_q    <= {reg_rdata[6:0], 1'b0};
                                    sda_oe_q   <= ~reg_rdata[7];
                                    bit_cnt_q  <= 4'd1;
                                    reg_addr_q <= reg_addr_q + 8'd1;
                                    state_q    <= S_RDATA;
                                end else if (state_q == S_ACK_DEV) begin
                                    state_q <= S_PTR;
                                end else begin
                                    state_q <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= S_MACK;
                            end else begin
                                sda_oe_q  <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    S_MACK: begin
                        if (scl_rise) begin
                            mack_q <= sda_f_q;
                        end else if (scl_fall) begin
                            if (!mack_q) begin
                                shift_q    <= {reg_rdata[6:0], 1'b0};
                                sda_oe_q   <= ~reg_rdata[7];
                                bit_cnt_q  <= 4'd1;
                                reg_addr_q <= reg_addr_q + 8'd1;
                                state_q    <= S_RDATA;
                            end else begin
                                state_q <= S_WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
